sc16_offset_add: RTL and testbench
==================================

SC16_OFFSET_ADD -- requirements
Module: sc16_offset_add

Interface
REQ-001 Parameter SR_BASE, default 8'd128, SHALL be the settings address of the offset register; the control register is SR_BASE+1.
REQ-002 Parameter RB_ADDR_BASE, default 8'd0, SHALL be the first readback address (three consecutive addresses used).
REQ-003 ce_clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 ce_rst_n  input  1  reset, synchronous, active-low.
REQ-005 set_stb  input  1  settings write strobe.
REQ-006 set_addr  input  8  settings address.
REQ-007 set_data  input  32  settings data.
REQ-008 rb_addr  input  8  readback address.
REQ-009 rb_data  output  64  registered readback data.
REQ-010 i_tdata  input  32  sc16 sample, I in [31:16], Q in [15:0], two's complement.
REQ-011 i_tlast  input  1  last sample of packet.
REQ-012 i_tvalid  input  1  input valid.
REQ-013 i_tready  output  1  input ready.
REQ-014 o_tdata  output  32  processed sample, same format.
REQ-015 o_tlast  output  1  registered copy of i_tlast.
REQ-016 o_tvalid  output  1  output valid.
REQ-017 o_tready  input  1  downstream ready.

Function
REQ-018 Offset register (SR_BASE) SHALL hold off_i = set_data[31:16] and off_q = set_data[15:0], signed.
REQ-019 Control register (SR_BASE+1): bit0 enable, bit1 saturate, bit2 clear_counters; bit2 SHALL be a one-cycle pulse, never stored.
REQ-020 Writes to offset, enable or saturate SHALL go to a pending copy; pending SHALL transfer to active when not mid-packet (no input handshake since the last tlast), else on the cycle after the input handshake carrying i_tlast.
REQ-021 in_packet flag SHALL set on an input handshake with i_tlast=0 and clear on one with i_tlast=1.
REQ-022 Pipeline SHALL be one register stage: i_tready = ~o_tvalid | o_tready (combinational); input handshake loads o_tdata/o_tlast and sets o_tvalid.
REQ-023 o_tvalid SHALL clear on an output handshake with no simultaneous input handshake; o_tdata/o_tlast SHALL hold while o_tvalid=1 and o_tready=0.
REQ-024 Latency SHALL be exactly one cycle; throughput one sample per cycle when o_tready stays high.
REQ-025 enable=0: o_tdata SHALL equal i_tdata bit-exact.
REQ-026 enable=1: each component SHALL be computed as 17-bit sign-extended sum of sample and active offset.
REQ-027 saturate=1: sums above 32767 SHALL output 16'h7FFF, below -32768 SHALL output 16'h8000; saturate=0: lower 16 bits (wrap).
REQ-028 Active settings SHALL be the ones applied to the sample at its input handshake.
REQ-029 sample_count (32-bit) SHALL increment per output handshake; packet_count (32-bit) per output handshake with o_tlast=1; both wrap 0xFFFFFFFF -> 0.
REQ-030 clear_counters SHALL zero both counters next cycle; coincident handshake SHALL NOT be counted (clear wins).
REQ-031 Readback, registered one cycle: RB_ADDR_BASE -> {32'd0, active offset}; +1 -> {61'd0, in_packet, saturate, enable} (active); +2 -> {packet_count, sample_count}; other -> 64'h0BADC0DE0BADC0DE.
REQ-032 Settings writes to addresses other than SR_BASE, SR_BASE+1 SHALL be ignored.

Reset
REQ-033 On ce_rst_n=0 at a clock edge: o_tvalid=0, o_tdata=0, o_tlast=0, rb_data=0, offsets (active, pending)=0, enable=0, saturate=1, in_packet=0, counters=0.
REQ-034 Reset mid-packet SHALL discard the held sample and drop the pending update; first post-reset sample SHALL start a new packet.
REQ-035 While ce_rst_n=0, i_tready SHALL be driven 0.

Verification
REQ-036 Bypass: enable=0, send 0x12345678 with tlast -> o_tdata 0x12345678 one cycle later, o_tlast=1, packet_count=1.
REQ-037 Saturation: offset 0x00100010, enable=1, saturate=1, input 0x7FF88000 -> 0x7FFF8010; saturate=0 -> 0x80088010.
REQ-038 Deferred update: 4-sample packet, write offset 0x00010001 after sample 2 -> samples 3-4 unchanged, next packet offset by +1/+1.
REQ-039 Backpressure: o_tready=0 for 5 cycles with i_tvalid=1 -> output held stable, i_tready=0, no samples lost or duplicated, count matches.
REQ-040 Counters: 3 packets of 10 samples -> readback +2 = 0x000000030000001E; clear_counters coincident with final handshake -> both 0.
REQ-041 Reset mid-packet with o_tvalid=1 -> o_tvalid=0 next cycle, readback +1 = 0x2, counters 0.

Source files
------------

// File: rtl/sc16_offset_add.sv
// -----------------------------------------------------------------------------
// sc16_offset_add
//
// Adds a programmable signed DC offset to each component of an sc16 sample
// stream, with optional saturation. There is one register stage between the
// input and output AXI-Stream ports. Settings writes go to a pending copy.
// The pending copy reaches the datapath only on a packet boundary, so every
// sample in a packet sees the same offset.
//
// Ports
//   ce_clk, ce_rst_n   clock and synchronous active-low reset
//   set_stb/addr/data  settings bus:
//                        SR_BASE   = {off_i, off_q}
//                        SR_BASE+1 = {.., clear_counters, saturate, enable}
//   rb_addr, rb_data   registered readback port:
//                        RB_ADDR_BASE + 0/1/2 = offset / status / counters
//   i_t*               input stream, I in [31:16], Q in [15:0]
//   o_t*               output stream, same format
// -----------------------------------------------------------------------------
module sc16_offset_add #(
    parameter logic [7:0] SR_BASE      = 8'd128,
    parameter logic [7:0] RB_ADDR_BASE = 8'd0
) (
    input  logic        ce_clk,
    input  logic        ce_rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [7:0]  rb_addr,
    output logic [63:0] rb_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam logic [7:0] SR_OFFSET = SR_BASE;
    localparam logic [7:0] SR_CTRL   = SR_BASE + 8'd1;
    localparam logic [7:0] RB_OFFSET = RB_ADDR_BASE;
    localparam logic [7:0] RB_STATUS = RB_ADDR_BASE + 8'd1;
    localparam logic [7:0] RB_COUNT  = RB_ADDR_BASE + 8'd2;

    logic [31:0] pend_off_reg, act_off_reg;
    logic        pend_en_reg, pend_sat_reg;
    logic        act_en_reg, act_sat_reg;
    logic        in_packet_reg;
    logic [31:0] sample_count_reg, packet_count_reg;

    logic        wr_offset, wr_ctrl, clr_counters;
    logic        in_hs, out_hs;
    logic [31:0] eff_off;
    logic        eff_en, eff_sat;
    logic [15:0] comp_next [2];
    logic [31:0] o_tdata_next;
    logic [63:0] rb_data_next;

    assign wr_offset    = set_stb && (set_addr == SR_OFFSET);
    assign wr_ctrl      = set_stb && (set_addr == SR_CTRL);
    assign clr_counters = wr_ctrl && set_data[2];

    // Ready is held low during reset so nothing can be accepted while the
    // stage is being flushed.
    assign i_tready = ce_rst_n & (~o_tvalid | o_tready);
    assign in_hs    = i_tvalid & i_tready;
    assign out_hs   = o_tvalid & o_tready;

    // Between packets, the active copy follows the pending copy one cycle
    // late. A packet-opening sample therefore uses the pending values
    // directly. This way the first sample after a boundary already sees
    // the latest write, and the active copy latches the same values on
    // that handshake.
    assign eff_off = in_packet_reg ? act_off_reg : pend_off_reg;
    assign eff_en  = in_packet_reg ? act_en_reg  : pend_en_reg;
    assign eff_sat = in_packet_reg ? act_sat_reg : pend_sat_reg;

    // gi = 1 is the I component [31:16], gi = 0 is the Q component [15:0].
    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        logic [15:0] smp, off;
        logic [16:0] sum;
        logic        ovf;

        assign smp = i_tdata[16*gi +: 16];
        assign off = eff_off[16*gi +: 16];
        assign sum = {smp[15], smp} + {off[15], off};
        // The 17-bit sum leaves the 16-bit range exactly when its top two
        // bits differ. Bit 16 then gives the direction of the overflow.
        assign ovf = sum[16] ^ sum[15];
        assign comp_next[gi] = !eff_en          ? smp :
                               (eff_sat && ovf) ? (sum[16] ? 16'h8000 : 16'h7FFF) :
                                                  sum[15:0];
    end

    assign o_tdata_next = {comp_next[1], comp_next[0]};

    always_comb begin
        rb_data_next = 64'h0BADC0DE0BADC0DE;
        case (rb_addr)
            RB_OFFSET: rb_data_next = {32'd0, act_off_reg};
            RB_STATUS: rb_data_next = {61'd0, in_packet_reg, act_sat_reg, act_en_reg};
            RB_COUNT:  rb_data_next = {packet_count_reg, sample_count_reg};
            default:   rb_data_next = 64'h0BADC0DE0BADC0DE;
        endcase
    end

    always_ff @(posedge ce_clk) begin
        if (!ce_rst_n) begin
            pend_off_reg     <= 32'd0;
            act_off_reg      <= 32'd0;
            pend_en_reg      <= 1'b0;
            act_en_reg       <= 1'b0;
            pend_sat_reg     <= 1'b1;
            act_sat_reg      <= 1'b1;
            in_packet_reg    <= 1'b0;
            o_tdata          <= 32'd0;
            o_tlast          <= 1'b0;
            o_tvalid         <= 1'b0;
            sample_count_reg <= 32'd0;
            packet_count_reg <= 32'd0;
            rb_data          <= 64'd0;
        end else begin
            if (wr_offset) begin
                pend_off_reg <= set_data;
            end
            if (wr_ctrl) begin
                pend_en_reg  <= set_data[0];
                pend_sat_reg <= set_data[1];
            end

            // Outside a packet, keep the active copy equal to the pending
            // copy. During a packet it stays frozen.
            if (!in_packet_reg) begin
                act_off_reg <= pend_off_reg;
                act_en_reg  <= pend_en_reg;
                act_sat_reg <= pend_sat_reg;
            end

            if (in_hs) begin
                in_packet_reg <= ~i_tlast;
                o_tdata       <= o_tdata_next;
                o_tlast       <= i_tlast;
                o_tvalid      <= 1'b1;
            end else if (out_hs) begin
                o_tvalid <= 1'b0;
            end

            // A clear takes priority over a handshake in the same cycle.
            if (clr_counters) begin
                sample_count_reg <= 32'd0;
                packet_count_reg <= 32'd0;
            end else if (out_hs) begin
                sample_count_reg <= sample_count_reg + 32'd1;
                if (o_tlast) begin
                    packet_count_reg <= packet_count_reg + 32'd1;
                end
            end

            rb_data <= rb_data_next;
        end
    end

endmodule

// File: tb/tb_sc16_offset_add.sv
// -----------------------------------------------------------------------------
// tb_sc16_offset_add
//
// Self-checking bench for sc16_offset_add.
//   - The predictor keeps a reference model of the settings. It sees each
//     input handshake and pushes the expected output word into exp_q.
//   - The monitor pops exp_q on each output handshake, compares the word,
//     and logs it to out_log.
// The bench drives inputs on posedge+1 and samples everything on negedge.
// -----------------------------------------------------------------------------
module tb_sc16_offset_add;

    localparam logic [7:0] SRB = 8'd128;
    localparam logic [7:0] RBB = 8'd0;

    logic        ce_clk   = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic        set_stb  = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [7:0]  rb_addr  = 8'd0;
    logic [63:0] rb_data;
    logic [31:0] i_tdata  = 32'd0;
    logic        i_tlast  = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;

    sc16_offset_add #(
        .SR_BASE      (SRB),
        .RB_ADDR_BASE (RBB)
    ) dut (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 ce_clk = ~ce_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sent_s = 32'd0;
    logic [31:0] sent_p = 32'd0;

    bit rand_bp    = 1'b0;
    bit hold_ready = 1'b1;

    // Reference model state: pending and active settings plus a packet flag.
    logic [31:0] m_p_off = 32'd0, m_a_off = 32'd0;
    bit          m_p_en = 1'b0, m_a_en = 1'b0;
    bit          m_p_sat = 1'b1, m_a_sat = 1'b1;
    bit          m_in_pkt = 1'b0;

    logic [32:0] exp_q [$];
    logic [32:0] out_log [$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] ref_comp(input logic [15:0] s, input logic [15:0] o,
                                             input bit en, input bit sat);
        int sum;
        if (!en) return s;
        sum = int'($signed(s)) + int'($signed(o));
        if (sat && sum > 32767)  return 16'h7FFF;
        if (sat && sum < -32768) return 16'h8000;
        return sum[15:0];
    endfunction

    // Predictor
    initial forever begin
        @(negedge ce_clk);
        if (!ce_rst_n) begin
            m_p_off = 32'd0; m_a_off = 32'd0;
            m_p_en = 1'b0;   m_a_en = 1'b0;
            m_p_sat = 1'b1;  m_a_sat = 1'b1;
            m_in_pkt = 1'b0;
            exp_q.delete();
        end else begin
            if (i_tvalid && i_tready) begin
                if (!m_in_pkt) begin
                    m_a_off = m_p_off; m_a_en = m_p_en; m_a_sat = m_p_sat;
                end
                exp_q.push_back({i_tlast,
                                 ref_comp(i_tdata[31:16], m_a_off[31:16], m_a_en, m_a_sat),
                                 ref_comp(i_tdata[15:0],  m_a_off[15:0],  m_a_en, m_a_sat)});
                m_in_pkt = !i_tlast;
            end
            if (set_stb && set_addr == SRB) m_p_off = set_data;
            if (set_stb && set_addr == SRB + 8'd1) begin
                m_p_en  = set_data[0];
                m_p_sat = set_data[1];
            end
        end
    end

    // Monitor
    initial forever begin
        logic [32:0] e;
        @(negedge ce_clk);
        if (ce_rst_n && o_tvalid && o_tready) begin
            out_log.push_back({o_tlast, o_tdata});
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard: unexpected output %h, expected none", {o_tlast, o_tdata});
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {31'd0, o_tlast, o_tdata}, {31'd0, e});
            end
        end
    end

    // Downstream ready driver
    initial forever begin
        @(posedge ce_clk); #1;
        if (rand_bp) o_tready = ($urandom_range(0, 3) != 0);
        else         o_tready = hold_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic [31:0] d, input logic l);
        int g = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        @(negedge ce_clk);
        while (!i_tready && g < 200) begin
            @(negedge ce_clk);
            g++;
        end
        if (!i_tready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: i_tready=0, expected 1");
        end else begin
            sent_s++;
            if (l) sent_p++;
        end
        @(posedge ce_clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge ce_clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic rb_check(input logic [7:0] a, input logic [63:0] e, input string name);
        rb_addr = a;
        @(posedge ce_clk); #1;
        @(negedge ce_clk);
        check(name, rb_data, e);
        @(posedge ce_clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        rand_bp = 1'b0; hold_ready = 1'b1;
        @(negedge ce_clk);
        while ((exp_q.size() != 0 || o_tvalid) && g < 500) begin
            @(negedge ce_clk);
            g++;
        end
        if (g >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", exp_q.size());
        end
        @(posedge ce_clk); #1;
    endtask

    initial begin
        int b;
        int len;
        logic [7:0] a;

        // Reset state
        ce_rst_n = 1'b0;
        repeat (3) @(posedge ce_clk);
        @(negedge ce_clk);
        check("reset_o_tvalid", o_tvalid, 0);
        check("reset_o_tdata",  o_tdata, 0);
        check("reset_o_tlast",  o_tlast, 0);
        check("reset_rb_data",  rb_data, 0);
        check("reset_i_tready", i_tready, 0);
        @(posedge ce_clk); #1;
        ce_rst_n = 1'b1;
        @(posedge ce_clk); #1;

        rb_check(RBB + 8'd1, 64'h2, "rb_status_reset");
        rb_check(RBB,        64'h0, "rb_offset_reset");
        rb_check(RBB + 8'd2, 64'h0, "rb_count_reset");
        rb_check(8'h37, 64'h0BADC0DE0BADC0DE, "rb_unmapped");

        // Bypass with one-cycle latency
        send(32'h12345678, 1'b1);
        @(negedge ce_clk);
        check("bypass_valid", o_tvalid, 1);
        check("bypass_data",  o_tdata, 32'h12345678);
        check("bypass_last",  o_tlast, 1);
        @(posedge ce_clk); #1;
        drain();
        rb_check(RBB + 8'd2, {32'd1, 32'd1}, "bypass_counts");

        // Saturation and wrap
        write_reg(SRB, 32'h00100010);
        write_reg(SRB + 8'd1, 32'h3);
        @(posedge ce_clk); #1;
        send(32'h7FF88000, 1'b1);
        @(negedge ce_clk);
        check("sat_on_data", o_tdata, 32'h7FFF8010);
        @(posedge ce_clk); #1;
        drain();
        write_reg(SRB + 8'd1, 32'h1);
        @(posedge ce_clk); #1;
        send(32'h7FF88000, 1'b1);
        @(negedge ce_clk);
        check("sat_off_data", o_tdata, 32'h80088010);
        @(posedge ce_clk); #1;
        drain();
        rb_check(RBB,        {32'd0, 32'h00100010}, "rb_offset");
        rb_check(RBB + 8'd1, 64'h1, "rb_status_wrap");

        // Offset written mid-packet is deferred to the next packet
        write_reg(SRB + 8'd1, 32'h3);
        write_reg(SRB, 32'h0);
        @(posedge ce_clk); #1;
        b = out_log.size();
        send(32'h01000200, 1'b0);
        send(32'h03000400, 1'b0);
        write_reg(SRB, 32'h00010001);
        send(32'h05000600, 1'b0);
        send(32'h07000800, 1'b1);
        send(32'h09000A00, 1'b0);
        send(32'h0B000C00, 1'b1);
        drain();
        if (out_log.size() < b + 6) begin
            n_cmp++; n_bad++;
            $display("FAIL deferred_count: got %0d outputs, expected %0d", out_log.size() - b, 6);
        end else begin
            check("deferred_s3", out_log[b+2], {1'b0, 32'h05000600});
            check("deferred_s4", out_log[b+3], {1'b1, 32'h07000800});
            check("deferred_s5", out_log[b+4], {1'b0, 32'h09010A01});
            check("deferred_s6", out_log[b+5], {1'b1, 32'h0B010C01});
        end

        // Backpressure: output held for 5 cycles
        hold_ready = 1'b0;
        @(posedge ce_clk); #1;
        b = out_log.size();
        fork
            begin
                send(32'h11112222, 1'b0);
                send(32'h33334444, 1'b1);
            end
            begin
                int g = 0;
                @(negedge ce_clk);
                while (!o_tvalid && g < 50) begin
                    @(negedge ce_clk);
                    g++;
                end
                repeat (5) begin
                    @(negedge ce_clk);
                    check("bp_hold_valid", o_tvalid, 1);
                    check("bp_hold_data",  o_tdata, 32'h11122223);
                    check("bp_tready_low", i_tready, 0);
                end
                hold_ready = 1'b1;
            end
        join
        drain();
        if (out_log.size() != b + 2) begin
            n_cmp++; n_bad++;
            $display("FAIL bp_count: got %0d outputs, expected 2", out_log.size() - b);
        end else begin
            check("bp_out0", out_log[b],   {1'b0, 32'h11122223});
            check("bp_out1", out_log[b+1], {1'b1, 32'h33344445});
        end
        rb_check(RBB + 8'd2, {sent_p, sent_s}, "bp_counts");

        // Counters: 3 packets of 10, then clear coincident with a handshake
        write_reg(SRB + 8'd1, 32'h7);
        sent_s = 32'd0; sent_p = 32'd0;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 10; s++)
                send($urandom, (s == 9));
        drain();
        rb_check(RBB + 8'd2, 64'h000000030000001E, "counters_3x10");
        send($urandom, 1'b1);
        write_reg(SRB + 8'd1, 32'h7);
        sent_s = 32'd0; sent_p = 32'd0;
        drain();
        rb_check(RBB + 8'd2, 64'h0, "counters_clear_wins");

        // Reset mid-packet with a held output
        hold_ready = 1'b0;
        @(posedge ce_clk); #1;
        send(32'h01010101, 1'b0);
        ce_rst_n = 1'b0;
        @(negedge ce_clk);
        check("rst_tready_low", i_tready, 0);
        @(posedge ce_clk); #1;
        ce_rst_n = 1'b1;
        hold_ready = 1'b1;
        sent_s = 32'd0; sent_p = 32'd0;
        @(negedge ce_clk);
        check("rst_mid_valid", o_tvalid, 0);
        @(posedge ce_clk); #1;
        rb_check(RBB + 8'd1, 64'h2, "rst_mid_status");
        rb_check(RBB + 8'd2, 64'h0, "rst_mid_counts");
        send(32'hCAFEBABE, 1'b1);
        drain();
        rb_check(RBB + 8'd1, 64'h2, "post_rst_status");

        // Randomized traffic with random settings and backpressure
        for (int p = 0; p < 30; p++) begin
            rand_bp = 1'b1;
            if ($urandom_range(0, 2) == 0) write_reg(SRB, $urandom);
            if ($urandom_range(0, 2) == 0) write_reg(SRB + 8'd1, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = 8'($urandom_range(0, 255));
                if (a == SRB || a == SRB + 8'd1) a = SRB + 8'd2;
                write_reg(a, $urandom);
            end
            len = $urandom_range(1, 8);
            for (int s = 0; s < len; s++) begin
                send($urandom, (s == len - 1));
                if ($urandom_range(0, 3) == 0) write_reg(SRB, $urandom);
                if ($urandom_range(0, 5) == 0) write_reg(SRB + 8'd1, $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge ce_clk); #1;
                end
            end
        end
        drain();
        @(posedge ce_clk); #1;
        rb_check(RBB + 8'd2, {sent_p, sent_s}, "rand_counts");
        rb_check(RBB,        {32'd0, m_p_off}, "rand_offset");
        rb_check(RBB + 8'd1, {61'd0, m_in_pkt, m_p_sat, m_p_en}, "rand_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
